// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read controller with a 2-entry buffer feeding a valid/ready stream
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  empty,
  input  logic                  almost_empty,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  low_water
);
  logic [1:0] occ;
  logic [2:0] lvl;
  logic inflight, head, tail, pop, head_n;
  logic [DATA_WIDTH-1:0] mem [2];
  assign pop = m_valid & m_ready;
  assign lvl = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en = ~rst & en & ~empty & (lvl < 3'd2);
  assign head_n = head ^ pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      inflight <= 1'b0;
      head <= 1'b0;
      tail <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      word_cnt <= '0;
      low_water <= 1'b0;
    end else begin
      occ <= lvl[1:0];
      inflight <= rd_en;
      head <= head_n;
      tail <= tail ^ inflight;
      if (inflight) mem[tail] <= dout;
      m_valid <= lvl != 3'd0;
      m_data <= (inflight && tail == head_n) ? dout : mem[head_n];
      word_cnt <= word_cnt + CNT_WIDTH'(pop);
      low_water <= almost_empty;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and random checks of fifo_rd_ctrl against a word-level stream model
module tb_fifo_rd_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, empty = 1'b1, almost_empty = 1'b1, m_ready = 1'b0;
  logic [7:0] dout = 8'h0;
  logic rd_en, m_valid, low_water, rd_en4, m_valid4, low_water4;
  logic [7:0] m_data, m_data4;
  logic [15:0] word_cnt;
  logic [3:0] word_cnt4;
  typedef struct {logic [7:0] d; int t;} ent_t;
  logic [7:0] fq[$];
  ent_t sb[$];
  int rd_cyc[$], pop_cyc[$];
  int cyc_no = 0, cnt = 0, n_cmp = 0, n_bad = 0, rd_pulses = 0, base_cnt;
  logic lw_exp = 1'b0;

  fifo_rd_ctrl dut (.clk(clk), .rst(rst), .en(en), .dout(dout), .empty(empty),
    .almost_empty(almost_empty), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .word_cnt(word_cnt), .low_water(low_water));
  fifo_rd_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en), .dout(dout),
    .empty(empty), .almost_empty(almost_empty), .rd_en(rd_en4), .m_data(m_data4),
    .m_valid(m_valid4), .m_ready(m_ready), .word_cnt(word_cnt4), .low_water(low_water4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    empty = fq.size() == 0;
    almost_empty = fq.size() <= 1;
  endtask

  task automatic cyc();
    logic exp_mv, exp_rd, pop, rd_s;
    @(negedge clk);
    exp_mv = sb.size() > 0 && sb[0].t <= cyc_no;
    pop = exp_mv && m_ready;
    exp_rd = !rst && en && !empty && (sb.size() - int'(pop)) < 2;
    rd_s = rd_en;
    chk("m_valid", m_valid, exp_mv);
    chk("m_valid4", m_valid4, exp_mv);
    if (exp_mv) chk("m_data", m_data, sb[0].d);
    if (exp_mv) chk("m_data4", m_data4, sb[0].d);
    chk("rd_en", rd_en, exp_rd);
    chk("rd_en4", rd_en4, exp_rd);
    chk("rd_while_empty", rd_en & empty, 0);
    chk("word_cnt", word_cnt, cnt & 16'hffff);
    chk("word_cnt4", word_cnt4, cnt & 4'hf);
    chk("low_water", low_water, lw_exp);
    chk("low_water4", low_water4, lw_exp);
    if (rd_s) begin
      rd_pulses++;
      rd_cyc.push_back(cyc_no);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      cnt = 0;
      lw_exp = 1'b0;
    end else begin
      if (pop) begin
        void'(sb.pop_front());
        cnt++;
        pop_cyc.push_back(cyc_no);
      end
      if (rd_s && fq.size() > 0) sb.push_back('{fq[0], cyc_no + 2});
      lw_exp = almost_empty;
    end
    cyc_no++;
    #1;
    if (rd_s && fq.size() > 0) dout = fq.pop_front();
    else dout = 8'($urandom);
    empty = fq.size() == 0;
    almost_empty = fq.size() <= 1;
  endtask

  initial begin
    en = 1'b1;
    push(16, 8'h01);
    @(posedge clk);
    #1;
    repeat (2) cyc();
    chk("reset_rd_pulses", rd_pulses, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_word_cnt", word_cnt, 0);
    rd_cyc.delete();
    pop_cyc.delete();
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (22) cyc();
    chk("stream_cnt", word_cnt, 16);
    chk("stream_pops", pop_cyc.size(), 16);
    if (pop_cyc.size() >= 16 && rd_cyc.size() > 0) begin
      chk("stream_span", pop_cyc[15] - pop_cyc[0], 15);
      chk("stream_latency", pop_cyc[0] - rd_cyc[0], 2);
      chk("first_rd_after_rst", rd_cyc[0], 2);
    end
    m_ready = 1'b0;
    push(8, 8'h01);
    rd_pulses = 0;
    repeat (6) cyc();
    chk("bp_rd_pulses", rd_pulses, 2);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_data", m_data, 8'h01);
    for (int i = 0; i < 26; i++) begin
      m_ready = i[0] ? 1'b0 : 1'b1;
      cyc();
    end
    chk("bp_cnt", word_cnt, 24);
    m_ready = 1'b1;
    push(4, 8'h21);
    base_cnt = cnt;
    cyc();
    en = 1'b0;
    rd_pulses = 0;
    repeat (5) cyc();
    chk("gate_no_rd", rd_pulses, 0);
    chk("gate_delivered", word_cnt, base_cnt + 1);
    en = 1'b1;
    cyc();
    chk("gate_resume", rd_pulses, 1);
    repeat (8) cyc();
    m_ready = 1'b0;
    push(6, 8'h40);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (10) cyc();
    chk("midrst_resume_cnt", word_cnt, 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push(17, 8'h60);
    repeat (22) cyc();
    chk("wrap_cnt4", word_cnt4, 1);
    chk("wrap_cnt16", word_cnt, 17);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      en = $urandom_range(0, 7) != 0;
      m_ready = $urandom_range(0, 3) != 0;
      if (fq.size() < 4 && $urandom_range(0, 2) == 0) push($urandom_range(1, 3), 8'($urandom));
      cyc();
    end
    rst = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    repeat (12) cyc();
    chk("final_drained", m_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
